// File: rtl/wb_writer_pkg.sv
// Shared definitions for the writeback writer: result source codes, FSM states,
// condition-code reset value and the packed queue entry layout.
package wb_writer_pkg;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_PC  = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;

    localparam int SRC_W  = 2;
    localparam int FLAG_W = 2;

    localparam logic [2:0] NZP_RST = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    // Entry layout, MSB first: {data, dr, src, wb, setcc}
    function automatic int entry_width(input int dw, input int aw);
        return dw + aw + SRC_W + FLAG_W;
    endfunction

endpackage

// File: rtl/wb_writer_queue.sv
// In-order result FIFO with a per-slot valid bit so the owner can scan every
// live entry (used for the pending-destination mask).
module wb_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [W-1:0]             second,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [W-1:0]             entries [DEPTH],
    output logic [DEPTH-1:0]         valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PW-1:0]    rd_r;
    logic [PW-1:0]    wr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    assign head    = mem_r[rd_r];
    assign second  = mem_r[rd_r + PW'(1)];
    assign count   = count_r;
    assign entries = mem_r;
    assign valid   = valid_r;

    // Storage, pointers (wrap modulo DEPTH) and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            valid_r <= {DEPTH{1'b0}};
            rd_r    <= {PW{1'b0}};
            wr_r    <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_r]   <= din;
                valid_r[wr_r] <= 1'b1;
                wr_r          <= wr_r + PW'(1);
            end
            if (pop_s) begin
                valid_r[rd_r] <= 1'b0;
                rd_r          <= rd_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback writer: queues Execute results, waits for load data where needed,
// issues one register-file write per result and maintains NZP.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [DW-1:0] res_data,
    input  logic [AW-1:0] res_dr,
    input  logic [1:0]    res_src,
    input  logic          res_wb,
    input  logic          res_setcc,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_dr,
    output logic [DW-1:0] rf_data,
    output logic [2:0]    nzp,
    output logic [7:0]    pend_mask
);

    localparam int EW       = entry_width(DW, AW);
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int DR_LSB   = SRC_W + FLAG_W;
    localparam int DATA_LSB = DR_LSB + AW;

    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [EW-1:0] head_s;
    logic [EW-1:0] second_s;
    logic [EW-1:0] entries_s [DEPTH];
    logic [DEPTH-1:0] valid_s;

    wb_queue #(.W(EW), .DEPTH(DEPTH)) u_queue (
        .clock   (clock),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .din     ({res_data, res_dr, res_src, res_wb, res_setcc}),
        .head    (head_s),
        .second  (second_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s),
        .entries (entries_s),
        .valid   (valid_s)
    );

    assign push_s    = res_valid && !full_s;
    assign res_ready = !full_s;

    logic [DW-1:0] head_data_s;
    logic [AW-1:0] head_dr_s;
    logic [1:0]    head_src_s;
    logic          head_wb_s;
    logic          head_setcc_s;
    logic [DW-1:0] sec_data_s;
    logic [AW-1:0] sec_dr_s;
    logic [1:0]    sec_src_s;
    logic          sec_wb_s;

    assign {head_data_s, head_dr_s, head_src_s, head_wb_s, head_setcc_s} = head_s;
    assign sec_data_s = second_s[EW-1 -: DW];
    assign sec_dr_s   = second_s[DATA_LSB-1 -: AW];
    assign sec_src_s  = second_s[DR_LSB-1 -: SRC_W];
    assign sec_wb_s   = second_s[1];

    function automatic logic [2:0] calc_nzp(input logic [DW-1:0] d);
        return {d[DW-1], (d == {DW{1'b0}}), (!d[DW-1]) && (d != {DW{1'b0}})};
    endfunction

    wb_state_e     state_r, next_state_s;
    logic          rf_we_r, rf_we_n_s;
    logic [AW-1:0] rf_dr_r, rf_dr_n_s;
    logic [DW-1:0] rf_data_r, rf_data_n_s;
    logic [2:0]    nzp_r, nzp_n_s;

    // Next-state and next write-port values from the head (and second) entry
    always_comb begin
        next_state_s = state_r;
        rf_we_n_s    = rf_we_r;
        rf_dr_n_s    = rf_dr_r;
        rf_data_n_s  = rf_data_r;
        nzp_n_s      = nzp_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rf_we_n_s = 1'b0;
                if (empty_s) begin
                    next_state_s = ST_IDLE;
                end else if (head_src_s == SRC_MEM) begin
                    next_state_s = ST_WAIT_MEM;
                end else begin
                    next_state_s = ST_WRITE;
                    rf_we_n_s    = head_wb_s;
                    rf_dr_n_s    = head_dr_s;
                    rf_data_n_s  = head_data_s;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_valid) begin
                    next_state_s = ST_WRITE;
                    rf_we_n_s    = head_wb_s;
                    rf_dr_n_s    = head_dr_s;
                    rf_data_n_s  = mem_data;
                end else begin
                    next_state_s = ST_WAIT_MEM;
                    rf_we_n_s    = 1'b0;
                end
            end
            ST_WRITE: begin
                pop_s = 1'b1;
                if (head_setcc_s) begin
                    nzp_n_s = calc_nzp(rf_data_r);
                end else begin
                    nzp_n_s = nzp_r;
                end
                // Only an entry already queued behind the head may go back-to-back
                if (count_s > CW'(1)) begin
                    if (sec_src_s == SRC_MEM) begin
                        next_state_s = ST_WAIT_MEM;
                        rf_we_n_s    = 1'b0;
                    end else begin
                        next_state_s = ST_WRITE;
                        rf_we_n_s    = sec_wb_s;
                        rf_dr_n_s    = sec_dr_s;
                        rf_data_n_s  = sec_data_s;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                    rf_we_n_s    = 1'b0;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                rf_we_n_s    = 1'b0;
            end
        endcase
    end

    // FSM state and registered write-port / condition-code outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            rf_we_r   <= 1'b0;
            rf_dr_r   <= {AW{1'b0}};
            rf_data_r <= {DW{1'b0}};
            nzp_r     <= NZP_RST;
        end else begin
            state_r   <= next_state_s;
            rf_we_r   <= rf_we_n_s;
            rf_dr_r   <= rf_dr_n_s;
            rf_data_r <= rf_data_n_s;
            nzp_r     <= nzp_n_s;
        end
    end

    assign rf_we   = rf_we_r;
    assign rf_dr   = rf_dr_r;
    assign rf_data = rf_data_r;
    assign nzp     = nzp_r;

    logic [7:0] pend_s;
    logic       unused_s;

    // Decode destinations of every live writing entry; head counts until popped
    always_comb begin
        pend_s   = 8'h00;
        unused_s = ^second_s;
        for (int i = 0; i < DEPTH; i++) begin
            pend_s[entries_s[i][DATA_LSB-1 -: AW]] =
                pend_s[entries_s[i][DATA_LSB-1 -: AW]] | (valid_s[i] & entries_s[i][1]);
            unused_s = unused_s ^ (^entries_s[i]);
        end
    end

    assign pend_mask = pend_s;

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: directed scenarios plus a randomized run
// checked against an in-order transaction model of expected writes.
module tb_wb_writer;

    logic        clock;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_dr;
    logic [1:0]  res_src;
    logic        res_wb;
    logic        res_setcc;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        rf_we;
    logic [2:0]  rf_dr;
    logic [15:0] rf_data;
    logic [2:0]  nzp;
    logic [7:0]  pend_mask;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  dr;
        logic [15:0] data;
        logic        setcc;
        logic        mem;
    } exp_t;

    exp_t exp_q[$];

    wb_writer dut (
        .clock     (clock),
        .reset     (reset),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_dr    (res_dr),
        .res_src   (res_src),
        .res_wb    (res_wb),
        .res_setcc (res_setcc),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_dr     (rf_dr),
        .rf_data   (rf_data),
        .nzp       (nzp),
        .pend_mask (pend_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] ref_nzp(input logic [15:0] d);
        if ($signed(d) < 0) return 3'b100;
        else if (d == 16'd0) return 3'b010;
        else return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_res(input logic [15:0] d, input logic [2:0] dr, input logic [1:0] src,
                             input logic wb, input logic sc);
        res_valid = 1'b1; res_data = d; res_dr = dr; res_src = src; res_wb = wb; res_setcc = sc;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; res_valid = 1'b0; res_data = 16'h0; res_dr = 3'd0; res_src = 2'd0;
        res_wb = 1'b0; res_setcc = 1'b0; mem_valid = 1'b0; mem_data = 16'h0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({rf_we, rf_dr, rf_data, nzp, pend_mask, res_ready} !== {1'b0, 3'd0, 16'h0, 3'b010, 8'h00, 1'b1})
            begin errors++; $display("FAIL reset_state: got %b_%h_%h_%b_%h_%b, expected 0_0_0000_010_00_1",
                rf_we, rf_dr, rf_data, nzp, pend_mask, res_ready); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_alu_write();
        drive_res(16'h1234, 3'd3, 2'd0, 1'b1, 1'b1);
        checks++;
        if ({rf_we, pend_mask} !== {1'b0, 8'h08})
            begin errors++; $display("FAIL alu_accept: got we=%b pend=%h, expected we=0 pend=08", rf_we, pend_mask); end
        tick();
        checks++;
        if ({rf_we, rf_dr, rf_data, pend_mask} !== {1'b1, 3'd3, 16'h1234, 8'h08})
            begin errors++; $display("FAIL alu_write: got we=%b dr=%0d data=%h pend=%h, expected 1 3 1234 08",
                rf_we, rf_dr, rf_data, pend_mask); end
        tick();
        checks++;
        if ({rf_we, nzp, pend_mask} !== {1'b0, 3'b001, 8'h00})
            begin errors++; $display("FAIL alu_done: got we=%b nzp=%b pend=%h, expected 0 001 00", rf_we, nzp, pend_mask); end
    endtask

    task automatic test_mem_wait();
        drive_res(16'hBEEF, 3'd5, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rf_we, pend_mask} !== {1'b0, 8'h20})
                begin errors++; $display("FAIL mem_wait[%0d]: got we=%b pend=%h, expected 0 20", i, rf_we, pend_mask); end
            tick();
        end
        mem_valid = 1'b1; mem_data = 16'h8000;
        tick();
        mem_valid = 1'b0;
        checks++;
        if ({rf_we, rf_dr, rf_data} !== {1'b1, 3'd5, 16'h8000})
            begin errors++; $display("FAIL mem_write: got we=%b dr=%0d data=%h, expected 1 5 8000", rf_we, rf_dr, rf_data); end
        tick();
        checks++;
        if ({rf_we, nzp, pend_mask} !== {1'b0, 3'b100, 8'h00})
            begin errors++; $display("FAIL mem_done: got we=%b nzp=%b pend=%h, expected 0 100 00", rf_we, nzp, pend_mask); end
    endtask

    task automatic test_back_to_back();
        drive_res(16'h0000, 3'd1, 2'd0, 1'b1, 1'b1);
        drive_res(16'h0007, 3'd2, 2'd1, 1'b1, 1'b1);
        checks++;
        if ({res_ready, rf_we, rf_dr, rf_data, pend_mask} !== {1'b0, 1'b1, 3'd1, 16'h0000, 8'h06})
            begin errors++; $display("FAIL b2b_first: got rdy=%b we=%b dr=%0d data=%h pend=%h, expected 0 1 1 0000 06",
                res_ready, rf_we, rf_dr, rf_data, pend_mask); end
        tick();
        checks++;
        if ({res_ready, rf_we, rf_dr, rf_data, nzp, pend_mask} !== {1'b1, 1'b1, 3'd2, 16'h0007, 3'b010, 8'h04})
            begin errors++; $display("FAIL b2b_second: got rdy=%b we=%b dr=%0d data=%h nzp=%b pend=%h, expected 1 1 2 0007 010 04",
                res_ready, rf_we, rf_dr, rf_data, nzp, pend_mask); end
        tick();
        checks++;
        if ({res_ready, rf_we, nzp, pend_mask} !== {1'b1, 1'b0, 3'b001, 8'h00})
            begin errors++; $display("FAIL b2b_done: got rdy=%b we=%b nzp=%b pend=%h, expected 1 0 001 00",
                res_ready, rf_we, nzp, pend_mask); end
    endtask

    task automatic test_no_wb();
        drive_res(16'hFFFF, 3'd6, 2'd0, 1'b0, 1'b1);
        checks++;
        if (pend_mask !== 8'h00)
            begin errors++; $display("FAIL nowb_pend: got %h, expected 00", pend_mask); end
        tick();
        checks++;
        if ({rf_we, pend_mask} !== {1'b0, 8'h00})
            begin errors++; $display("FAIL nowb_we: got we=%b pend=%h, expected 0 00", rf_we, pend_mask); end
        tick();
        checks++;
        if ({rf_we, nzp} !== {1'b0, 3'b100})
            begin errors++; $display("FAIL nowb_nzp: got we=%b nzp=%b, expected 0 100", rf_we, nzp); end
    endtask

    task automatic test_early_mem();
        mem_valid = 1'b1; mem_data = 16'h1111;
        tick();
        mem_valid = 1'b0;
        drive_res(16'h5555, 3'd4, 2'd2, 1'b1, 1'b0);
        tick();
        tick();
        checks++;
        if (rf_we !== 1'b0)
            begin errors++; $display("FAIL early_mem_hold: got we=%b, expected 0", rf_we); end
        mem_valid = 1'b1; mem_data = 16'h2222;
        tick();
        mem_valid = 1'b0;
        checks++;
        if ({rf_we, rf_dr, rf_data} !== {1'b1, 3'd4, 16'h2222})
            begin errors++; $display("FAIL early_mem_write: got we=%b dr=%0d data=%h, expected 1 4 2222", rf_we, rf_dr, rf_data); end
        tick();
        checks++;
        if ({rf_we, nzp} !== {1'b0, 3'b100})
            begin errors++; $display("FAIL early_mem_done: got we=%b nzp=%b, expected 0 100", rf_we, nzp); end
    endtask

    task automatic test_reset_mid();
        drive_res(16'h0000, 3'd1, 2'd2, 1'b1, 1'b1);
        drive_res(16'h0009, 3'd2, 2'd0, 1'b1, 1'b1);
        checks++;
        if ({res_ready, pend_mask} !== {1'b0, 8'h06})
            begin errors++; $display("FAIL rst_mid_pre: got rdy=%b pend=%h, expected 0 06", res_ready, pend_mask); end
        reset = 1'b0;
        #1;
        checks++;
        if ({rf_we, pend_mask, res_ready, nzp} !== {1'b0, 8'h00, 1'b1, 3'b010})
            begin errors++; $display("FAIL rst_mid_now: got we=%b pend=%h rdy=%b nzp=%b, expected 0 00 1 010",
                rf_we, pend_mask, res_ready, nzp); end
        tick();
        reset = 1'b1;
        mem_valid = 1'b1; mem_data = 16'hABCD;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_valid = 1'b0;
            checks++;
            if ({rf_we, pend_mask, nzp} !== {1'b0, 8'h00, 3'b010})
                begin errors++; $display("FAIL rst_mid_after[%0d]: got we=%b pend=%h nzp=%b, expected 0 00 010",
                    i, rf_we, pend_mask, nzp); end
        end
    endtask

    task automatic test_random();
        exp_t        e;
        exp_t        drv_e;
        bit          drv = 1'b0;
        bit          upd = 1'b0;
        bit          done = 1'b0;
        logic [2:0]  upd_val = 3'b000;
        logic [2:0]  model_nzp = 3'b010;
        logic [7:0]  mask;
        int          qn;
        bit          found;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            tick();
            if (drv) exp_q.push_back(drv_e);
            drv = 1'b0;
            if (upd) model_nzp = upd_val;
            upd = 1'b0;
            checks++;
            if (nzp !== model_nzp)
                begin errors++; $display("FAIL rand_nzp@%0d: got %b, expected %b", cyc, nzp, model_nzp); end
            mask = 8'h00;
            foreach (exp_q[k]) mask[exp_q[k].dr] = 1'b1;
            checks++;
            if (pend_mask !== mask)
                begin errors++; $display("FAIL rand_pend@%0d: got %h, expected %h", cyc, pend_mask, mask); end
            qn = exp_q.size();
            checks++;
            if (res_ready !== (qn < 2))
                begin errors++; $display("FAIL rand_ready@%0d: got %b, expected %b", cyc, res_ready, (qn < 2)); end
            if (rf_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious@%0d: write dr=%0d data=%h with nothing queued", cyc, rf_dr, rf_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({rf_dr, rf_data} !== {e.dr, e.data})
                        begin errors++; $display("FAIL rand_write@%0d: got dr=%0d data=%h, expected dr=%0d data=%h",
                            cyc, rf_dr, rf_data, e.dr, e.data); end
                    if (e.setcc) begin upd = 1'b1; upd_val = ref_nzp(e.data); end
                end
            end
            if (cyc < 500) begin
                res_valid = ($urandom_range(0, 3) != 0);
                res_src   = 2'($urandom_range(0, 3));
                res_dr    = 3'($urandom_range(0, 7));
                res_data  = 16'($urandom);
                res_wb    = 1'b1;
                res_setcc = 1'($urandom_range(0, 1));
                drv       = res_valid && (qn < 2);
                drv_e.dr    = res_dr;
                drv_e.setcc = res_setcc;
                drv_e.mem   = (res_src == 2'd2);
                drv_e.data  = drv_e.mem ? 16'($urandom) : res_data;
            end else begin
                res_valid = 1'b0;
                done = (exp_q.size() == 0) && !upd;
            end
            found = 1'b0;
            mem_data = 16'($urandom);
            foreach (exp_q[k]) if (!found && exp_q[k].mem) begin found = 1'b1; mem_data = exp_q[k].data; end
            mem_valid = ($urandom_range(0, 3) == 0);
        end
        res_valid = 1'b0;
        mem_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0)
            begin errors++; $display("FAIL rand_drain: %0d writes still outstanding, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_mem_wait();
        test_back_to_back();
        test_no_wb();
        test_early_mem();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
Writeback-side writer for the 8x16 register file. It accepts completed results from Execute over a valid/ready handshake and buffers them in a small in-order queue. For load results it waits for Memory read data. It then issues one register-file write strobe per result, with destination ID and data, and maintains the NZP condition codes. It also exports a pending-destination mask that Decode uses for RAW hazard stalls.

Parameters:
DEPTH, 2, result queue entries (power of 2, min 2)
DW, 16, data width
AW, 3, register ID width (8 registers)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
res_valid  in  1  Execute result valid
res_ready  out  1  queue can accept; = (count != DEPTH)
res_data  in  DW  ALU/PC result; ignored when res_src=MEM
res_dr  in  AW  destination register ID
res_src  in  2  0=ALU, 1=PC, 2=MEM (load), 3=reserved (treated as ALU)
res_wb  in  1  1 = result writes a register
res_setcc  in  1  1 = update NZP from written value
mem_valid  in  1  Memory read data valid (one-cycle pulse)
mem_data  in  DW  Memory read data
rf_we  out  1  register-file write strobe, registered
rf_dr  out  AW  write register ID, registered
rf_data  out  DW  write data, registered
nzp  out  3  condition codes {N,Z,P}, registered
pend_mask  out  8  bit i set = some queued entry with res_wb=1 targets Ri

Behaviour:
- Reset (reset=0, async):
  - Queue empty, FSM to IDLE.
  - rf_we=0, rf_dr=0, rf_data=0, nzp=3'b010, pend_mask=0.
  - res_ready=1 while the queue is empty.
- Push: res_valid && res_ready at a rising edge enqueues {data, dr, src, wb, setcc}.
  - res_ready depends only on count. There is no bypass: when full, a same-cycle pop does not allow a push.
- pend_mask: combinational OR over all valid queue entries with wb=1, decoded by dr.
  - The head entry stays counted until its WRITE cycle completes.
- FSM on the head entry:
  - IDLE:
    - If the queue is non-empty and head.src=MEM, go to WAIT_MEM.
    - If the queue is non-empty and head.src is not MEM, go to WRITE, loading rf_data=head.data, rf_dr=head.dr, rf_we=head.wb.
  - WAIT_MEM: hold until mem_valid=1, then go to WRITE, loading rf_data=mem_data, rf_dr=head.dr, rf_we=head.wb.
  - WRITE: exactly one cycle with rf_we high (when wb=1).
    - At the closing edge: pop the head. If head.setcc, nzp becomes {data[15], data==0, !data[15] && data!=0}.
    - Next state is decided from the second entry as held at the start of the cycle: non-MEM goes to WRITE (back-to-back, one write per cycle); MEM goes to WAIT_MEM; absent goes to IDLE.
    - An entry pushed during this cycle is picked up through IDLE.
  - Leaving WRITE to any state other than WRITE clears rf_we.
- Latency: a non-MEM result accepted at edge T produces rf_we=1 during cycle T+1→T+2; the register file captures it at edge T+2.
  - For a MEM result, rf_we rises at the edge after mem_valid is sampled.
- Entries with wb=0:
  - They still occupy one WRITE cycle with rf_we=0, which preserves order.
  - setcc is still honoured.
  - wb=0 with src=MEM still waits for mem_valid.
- mem_valid outside WAIT_MEM is ignored and its data dropped.
- The queue pointers wrap modulo DEPTH; count is held as AW-independent $clog2(DEPTH)+1 bits.
- Reset mid-operation: any in-flight write is abandoned, with no partial rf_we.

Decomposition:
- Shared package:
  - res_src encodings (SRC_ALU, SRC_PC, SRC_MEM)
  - FSM state constants (IDLE, WAIT_MEM, WRITE)
  - NZP reset constant 3'b010
  - queue entry field widths
- One sub-module: wb_queue, a synchronous FIFO with count, full/empty and entry-array visibility for pend_mask.

Test Plan:
- Reset, then push ALU {data=16'h1234, dr=3, wb=1, setcc=1} at edge T → rf_we=1, rf_dr=3, rf_data=16'h1234 during T+1; nzp=3'b001 after T+2; pend_mask=8'h08 from T until T+2, then 0.
- Push MEM {dr=5} and hold mem_valid=0 for 4 cycles → FSM stays in WAIT_MEM, rf_we=0, pend_mask=8'h20. Then pulse mem_valid with mem_data=16'h8000 → write R5=16'h8000 next cycle; nzp=3'b100.
- Fill the queue with two ALU entries (dr=1, data=0; dr=2, data=7), both with setcc=1 → res_ready=0 after the second push. Writes occur on consecutive cycles; nzp ends at 3'b010 then 3'b001; res_ready returns to 1.
- Entry with wb=0 and setcc=1, data=16'hFFFF → rf_we stays 0, nzp=3'b100, pend_mask stays 0.
- mem_valid pulsed while IDLE, then a MEM entry pushed → the early data is ignored and the write waits for the next mem_valid.
- Assert reset during WAIT_MEM with 2 entries queued → rf_we=0, pend_mask=0, res_ready=1, nzp=3'b010 immediately; no write after release.
